// File: rtl/conv3x3_mac_engine_pkg.sv
// Shared constants, FSM encoding and saturation helper for the 3x3 conv MAC engine
// and the downstream fully-connected stage.
package conv3x3_mac_engine_pkg;

   localparam int unsigned DATA_W_DEF    = 16;
   localparam int unsigned FRAC_BITS_DEF = 8;
   localparam int unsigned ACC_W         = 2 * DATA_W_DEF + 4;

   typedef enum logic [1:0] {
      StIdle,
      StFetch,
      StLatch,
      StRun
   } state_e;

   // Clamp a signed ACC_W value into the signed range of a w-bit word (result still ACC_W wide).
   function automatic logic [ACC_W-1:0] saturate(input logic [ACC_W-1:0] v, input int unsigned w);
      logic signed [ACC_W-1:0] sv;
      logic signed [ACC_W-1:0] hi;
      logic signed [ACC_W-1:0] lo;
      sv = $signed(v);
      hi = (ACC_W'(1) << (w - 1)) - ACC_W'(1);
      lo = ~hi;
      if (sv > hi) begin
         return hi;
      end else if (sv < lo) begin
         return lo;
      end
      return sv;
   endfunction

endpackage

// File: rtl/conv3x3_sat_quant.sv
// Requantize a wide signed accumulator: arithmetic shift (floor), saturate, optional ReLU.
// Purely combinational so it can sit in the last pipeline stage of either compute engine.
module conv3x3_sat_quant
   import conv3x3_mac_engine_pkg::*;
#(
   parameter int unsigned DATA_W    = DATA_W_DEF,
   parameter int unsigned FRAC_BITS = FRAC_BITS_DEF,
   parameter int unsigned IN_W      = ACC_W
) (
   input  logic [IN_W-1:0]   acc_i,
   input  logic              relu_en_i,
   output logic [DATA_W-1:0] res_o
);

   logic signed [IN_W-1:0]  shifted;
   logic signed [ACC_W-1:0] sat;

   // Floor shift, clamp to the output range, then zero negatives when ReLU is on.
   always_comb begin
      shifted = $signed(acc_i) >>> FRAC_BITS;
      sat     = saturate(ACC_W'(shifted), DATA_W);
      res_o   = sat[DATA_W-1:0];
      if (relu_en_i && sat[ACC_W-1]) begin
         res_o = '0;
      end
   end

endmodule

// File: rtl/conv3x3_mac_engine.sv
// 3x3 signed MAC engine: fetches one filter set (9 weights + bias) from the filter memory,
// then streams pixel windows through a 3-stage pipeline (multiply, row sums, bias+requant).
module conv3x3_mac_engine
   import conv3x3_mac_engine_pkg::*;
#(
   parameter int unsigned DATA_W    = DATA_W_DEF,
   parameter int unsigned FRAC_BITS = FRAC_BITS_DEF,
   parameter int unsigned ADDR_W    = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load_req,
   input  logic [ADDR_W-1:0]     filter_base,
   output logic                  load_done,
   output logic                  mem_en,
   output logic [ADDR_W-1:0]     mem_addr,
   input  logic [DATA_W-1:0]     mem_w0,
   input  logic [DATA_W-1:0]     mem_w1,
   input  logic [DATA_W-1:0]     mem_w2,
   input  logic [DATA_W-1:0]     mem_w3,
   input  logic [DATA_W-1:0]     mem_w4,
   input  logic [DATA_W-1:0]     mem_w5,
   input  logic [DATA_W-1:0]     mem_w6,
   input  logic [DATA_W-1:0]     mem_w7,
   input  logic [DATA_W-1:0]     mem_w8,
   input  logic [DATA_W-1:0]     mem_bias,
   input  logic                  relu_en,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [9*DATA_W-1:0]   in_pix,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_W-1:0]     out_data,
   output logic                  busy
);

   localparam int unsigned PW = 2 * DATA_W;  // product width
   localparam int unsigned RW = PW + 2;      // row-sum width
   localparam int unsigned AW = PW + 4;      // accumulator width

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] w_q [9];
   logic [DATA_W-1:0] w_d [9];
   logic [DATA_W-1:0] bias_q, bias_d;
   logic [DATA_W-1:0] mem_w [9];

   logic              s1_valid_q, s1_valid_d;
   logic              s2_valid_q, s2_valid_d;
   logic              s3_valid_q, s3_valid_d;
   logic [PW-1:0]     p_q [9];
   logic [PW-1:0]     p_d [9];
   logic [RW-1:0]     r_q [3];
   logic [RW-1:0]     r_d [3];
   logic [DATA_W-1:0] out_q, out_d;

   logic              pipe_empty;
   logic              advance;
   logic              load_ok;
   logic              in_fire;
   logic [AW-1:0]     acc;
   logic [DATA_W-1:0] sq_res;

   // Gather the memory weight ports into an indexable array.
   always_comb begin
      mem_w = '{mem_w0, mem_w1, mem_w2, mem_w3, mem_w4, mem_w5, mem_w6, mem_w7, mem_w8};
   end

   // Handshake, load arbitration and port outputs.
   always_comb begin
      pipe_empty = ~(s1_valid_q | s2_valid_q | s3_valid_q);
      advance    = ~s3_valid_q | out_ready;
      // A reload in RUN is only taken once the pipeline has drained; it beats a new window.
      load_ok    = load_req & ((state_q == StIdle) | ((state_q == StRun) & pipe_empty));
      in_ready   = (state_q == StRun) & advance & ~load_ok;
      in_fire    = in_valid & in_ready;
      mem_en     = (state_q == StFetch);
      mem_addr   = addr_q;
      load_done  = (state_q == StLatch);
      out_valid  = s3_valid_q;
      out_data   = out_q;
      busy       = ((state_q != StIdle) & (state_q != StRun)) | ~pipe_empty;
   end

   // Filter-load FSM: the memory answers one cycle after FETCH, so capture happens in LATCH.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      w_d     = w_q;
      bias_d  = bias_q;
      case (state_q)
         StIdle, StRun: begin
            if (load_ok) begin
               state_d = StFetch;
               addr_d  = filter_base;
            end
         end
         StFetch: state_d = StLatch;
         StLatch: begin
            w_d     = mem_w;
            bias_d  = mem_bias;
            state_d = StRun;
         end
         default: state_d = StIdle;
      endcase
   end

   // Stage 3 accumulator: row sums plus bias aligned to the product's fractional point.
   always_comb begin
      acc = AW'($signed(r_q[0])) + AW'($signed(r_q[1])) + AW'($signed(r_q[2]))
            + (AW'($signed(bias_q)) <<< FRAC_BITS);
   end

   conv3x3_sat_quant #(
      .DATA_W    (DATA_W),
      .FRAC_BITS (FRAC_BITS),
      .IN_W      (AW)
   ) u_sat_quant (
      .acc_i     (acc),
      .relu_en_i (relu_en),
      .res_o     (sq_res)
   );

   // Pipeline next state; every stage freezes together when the output is stalled.
   always_comb begin
      s1_valid_d = s1_valid_q;
      s2_valid_d = s2_valid_q;
      s3_valid_d = s3_valid_q;
      p_d        = p_q;
      r_d        = r_q;
      out_d      = out_q;
      if (advance) begin
         s1_valid_d = in_fire;
         s2_valid_d = s1_valid_q;
         s3_valid_d = s2_valid_q;
         if (in_fire) begin
            for (int k = 0; k < 9; k++) begin
               p_d[k] = PW'($signed(w_q[k])) * PW'($signed(in_pix[k*DATA_W +: DATA_W]));
            end
         end
         if (s1_valid_q) begin
            for (int i = 0; i < 3; i++) begin
               r_d[i] = RW'($signed(p_q[3*i])) + RW'($signed(p_q[3*i+1]))
                        + RW'($signed(p_q[3*i+2]));
            end
         end
         if (s2_valid_q) begin
            out_d = sq_res;
         end
      end
   end

   // State registers; reset discards in-flight windows and clears the filter set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         addr_q     <= '0;
         w_q        <= '{default: '0};
         bias_q     <= '0;
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         s3_valid_q <= 1'b0;
         p_q        <= '{default: '0};
         r_q        <= '{default: '0};
         out_q      <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         w_q        <= w_d;
         bias_q     <= bias_d;
         s1_valid_q <= s1_valid_d;
         s2_valid_q <= s2_valid_d;
         s3_valid_q <= s3_valid_d;
         p_q        <= p_d;
         r_q        <= r_d;
         out_q      <= out_d;
      end
   end

endmodule

// File: tb/tb_conv3x3_mac_engine.sv
// Scoreboard bench for conv3x3_mac_engine: the driver pushes hand-computed results as windows
// are accepted, a separate monitor pops and compares on every output handshake.
module tb_conv3x3_mac_engine;

   logic         clk;
   logic         rst_n;
   logic         load_req;
   logic [3:0]   filter_base;
   logic         load_done;
   logic         mem_en;
   logic [3:0]   mem_addr;
   logic [15:0]  rd_w [9];
   logic [15:0]  rd_b;
   logic         relu_en;
   logic         in_valid;
   logic         in_ready;
   logic [143:0] in_pix;
   logic         out_valid;
   logic         out_ready;
   logic [15:0]  out_data;
   logic         busy;

   logic [15:0]  tbl_w [16][9];
   logic [15:0]  tbl_b [16];

   typedef struct {
      logic [15:0] data;
      bit          lat;
      int          t;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   bit   tog     = 0;

   conv3x3_mac_engine dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .load_req    (load_req),
      .filter_base (filter_base),
      .load_done   (load_done),
      .mem_en      (mem_en),
      .mem_addr    (mem_addr),
      .mem_w0      (rd_w[0]),
      .mem_w1      (rd_w[1]),
      .mem_w2      (rd_w[2]),
      .mem_w3      (rd_w[3]),
      .mem_w4      (rd_w[4]),
      .mem_w5      (rd_w[5]),
      .mem_w6      (rd_w[6]),
      .mem_w7      (rd_w[7]),
      .mem_w8      (rd_w[8]),
      .mem_bias    (rd_b),
      .relu_en     (relu_en),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_pix      (in_pix),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .busy        (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Filter memory model with one-cycle read latency.
   always @(posedge clk) begin
      if (mem_en) begin
         for (int k = 0; k < 9; k++) rd_w[k] <= tbl_w[mem_addr][k];
         rd_b <= tbl_b[mem_addr];
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [143:0] win_all(input logic [15:0] v);
      logic [143:0] r;
      for (int k = 0; k < 9; k++) r[k*16 +: 16] = v;
      return r;
   endfunction

   function automatic logic [143:0] win_one(input int k, input logic [15:0] v);
      logic [143:0] r;
      r = '0;
      r[k*16 +: 16] = v;
      return r;
   endfunction

   // Called at a falling edge; returns at a falling edge in RUN.
   task automatic do_load(input logic [3:0] base);
      load_req    = 1'b1;
      filter_base = base;
      #1;
      if (in_valid) check("load_wins_in_ready", in_ready, 0);
      @(negedge clk);
      load_req = 1'b0;
      in_valid = 1'b0;
      #1;
      check("fetch_mem_en", mem_en, 1);
      check("fetch_mem_addr", mem_addr, base);
      check("fetch_load_done", load_done, 0);
      @(negedge clk);
      #1;
      check("latch_load_done", load_done, 1);
      check("latch_mem_en", mem_en, 0);
      check("latch_busy", busy, 1);
      @(negedge clk);
      #1;
      check("run_load_done", load_done, 0);
      check("run_busy", busy, 0);
      @(negedge clk);
   endtask

   // Present a window until accepted, recording the expected result.
   task automatic send(input logic [143:0] pix, input logic [15:0] exp, input bit lat);
      exp_t e;
      in_valid = 1'b1;
      in_pix   = pix;
      for (int i = 0; i < 64; i++) begin
         #1;
         if (in_ready) begin
            e.data = exp;
            e.lat  = lat;
            e.t    = cyc;
            sb.push_back(e);
            @(negedge clk);
            in_valid = 1'b0;
            return;
         end
         @(negedge clk);
      end
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: actual=in_ready low 64 cycles required=accept");
      in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 64 && sb.size() != 0; i++) @(negedge clk);
      check("drain_empty", sb.size(), 0);
   endtask

   // out_ready toggler for the back-pressure test.
   initial begin
      forever begin
         @(negedge clk);
         if (tog) out_ready = ~out_ready;
      end
   end

   // Monitor: compares on each handshake and checks that stalled output is held.
   initial begin
      exp_t        e;
      bit          hold;
      logic [15:0] held;
      hold = 0;
      held = '0;
      forever begin
         @(negedge clk);
         #2;
         if (!rst_n) begin
            hold = 0;
            continue;
         end
         if (hold) begin
            check("hold_valid", out_valid, 1);
            check("hold_data", out_data, held);
         end
         if (out_valid && out_ready) begin
            hold = 0;
            if (sb.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_out: actual=%0h required=no output", out_data);
            end else begin
               e = sb.pop_front();
               check("out_data", out_data, e.data);
               if (e.lat) check("latency", cyc - e.t, 3);
            end
         end else if (out_valid) begin
            hold = 1;
            held = out_data;
         end else begin
            hold = 0;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: actual=still running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] exp5 [8];
      logic [15:0] exp_lane [9];
      exp5     = '{16'd2304, 16'd4608, 16'd6912, 16'd9216,
                   16'd11520, 16'd13824, 16'd16128, 16'd18432};
      exp_lane = '{16'hFF00, 16'h0000, 16'h0100, 16'h0200, 16'h0300,
                   16'h0400, 16'h0500, 16'h0600, 16'h0700};

      for (int a = 0; a < 16; a++) begin
         for (int k = 0; k < 9; k++) tbl_w[a][k] = '0;
         tbl_b[a] = '0;
      end
      for (int k = 0; k < 9; k++) begin
         tbl_w[0][k] = 16'h0100;
         tbl_w[1][k] = 16'h7FFF;
         tbl_w[2][k] = 16'h8000;
         tbl_w[3][k] = 16'h0100;
         tbl_w[4][k] = 16'((k + 1) * 256);
         tbl_w[5][k] = 16'h0001;
         rd_w[k]     = '0;
      end
      tbl_b[3] = 16'h0100;
      tbl_b[4] = 16'hFE00;
      rd_b     = '0;

      rst_n       = 1'b0;
      load_req    = 1'b0;
      filter_base = '0;
      relu_en     = 1'b0;
      in_valid    = 1'b0;
      in_pix      = '0;
      out_ready   = 1'b1;

      // Reset state
      repeat (3) @(negedge clk);
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_mem_en", mem_en, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_load_done", load_done, 0);
      check("rst_busy", busy, 0);
      check("rst_in_ready", in_ready, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Load base 0 and unit-weight window, exact latency
      do_load(4'd0);
      send(win_all(16'h0100), 16'd2304, 1);
      drain();

      // Eight windows under 1010 back-pressure
      tog = 1;
      for (int n = 0; n < 8; n++) send(win_all(16'((n + 1) * 256)), exp5[n], 0);
      drain();
      tog       = 0;
      out_ready = 1'b1;
      @(negedge clk);

      // Reload request while a window is in flight is dropped
      send(win_all(16'h0100), 16'd2304, 0);
      load_req    = 1'b1;
      filter_base = 4'd1;
      @(negedge clk);
      load_req = 1'b0;
      #1;
      check("load_ignored_mem_en", mem_en, 0);
      @(negedge clk);
      drain();

      // Positive and negative saturation; second load collides with a window
      do_load(4'd1);
      send(win_all(16'h7FFF), 16'h7FFF, 0);
      drain();
      in_valid = 1'b1;
      in_pix   = win_all(16'h7FFF);
      do_load(4'd2);
      send(win_all(16'h7FFF), 16'h8000, 0);
      drain();

      // Bias with ReLU on and off
      do_load(4'd3);
      relu_en = 1'b1;
      send(win_all(16'hFF00), 16'h0000, 0);
      drain();
      relu_en = 1'b0;
      send(win_all(16'hFF00), 16'hF800, 0);
      drain();

      // Lane mapping: w_k = k+1, bias = -2.0
      do_load(4'd4);
      for (int k = 0; k < 9; k++) send(win_one(k, 16'h0100), exp_lane[k], 0);
      send(win_all(16'h0100), 16'd11008, 0);
      drain();

      // Requantization floors toward -inf
      do_load(4'd5);
      send(win_one(0, 16'hFFFF), 16'hFFFF, 0);
      send(win_one(0, 16'h00FF), 16'h0000, 0);
      send(win_one(4, 16'h0100), 16'h0001, 0);
      drain();

      // Reset with windows in flight and one stalled at the output
      do_load(4'd0);
      out_ready = 1'b0;
      send(win_all(16'h0100), 16'd2304, 0);
      send(win_all(16'h0200), 16'd4608, 0);
      @(negedge clk);
      #1;
      check("pre_reset_out_valid", out_valid, 1);
      rst_n = 1'b0;
      sb.delete();
      #1;
      check("reset_out_valid", out_valid, 0);
      check("reset_busy", busy, 0);
      check("reset_in_ready", in_ready, 0);
      @(negedge clk);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_pix    = win_all(16'h0100);
      for (int i = 0; i < 6; i++) begin
         #1;
         check("post_reset_in_ready", in_ready, 0);
         check("post_reset_out_valid", out_valid, 0);
         @(negedge clk);
      end
      in_valid = 1'b0;
      do_load(4'd0);
      send(win_all(16'h0100), 16'd2304, 1);
      drain();

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
